pipelined_csel_adder: RTL
=========================

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand/sum width in bits; SHALL be a multiple of BLK.
REQ-002 Parameter BLK, default 4: carry-select block width in bits; NBLK = WIDTH/BLK pipeline stages.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: operands and mode on the input side are valid this cycle.
REQ-006 Port in_ready, output, 1: block accepts an operation this cycle.
REQ-007 Port A, input, WIDTH: operand A.
REQ-008 Port B, input, WIDTH: operand B.
REQ-009 Port C_IN, input, 1: carry-in (add mode only).
REQ-010 Port SUB, input, 1: 0 = A+B+C_IN; 1 = A-B (A + ~B + 1, C_IN ignored).
REQ-011 Port out_valid, output, 1: SUM/C_OUT/OVF hold a completed result.
REQ-012 Port out_ready, input, 1: downstream accepts the result this cycle.
REQ-013 Port SUM, output, WIDTH: result modulo 2^WIDTH.
REQ-014 Port C_OUT, output, 1: carry out of the MSB (in SUB mode, 1 = no borrow).
REQ-015 Port OVF, output, 1: signed two's-complement overflow.

Function
REQ-016 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-017 Global advance signal adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-018 When adv = 0, every pipeline register (data and valid bits) SHALL hold its value.
REQ-019 Stage k (k = 0..NBLK-1) SHALL compute operand bits [k*BLK +: BLK] with two BLK-bit ripple sums (carry-in 0 and 1), then select with the carry registered from stage k-1 (stage 0 uses the effective carry-in).
REQ-020 Bits for not-yet-processed blocks SHALL be carried forward in skew registers; completed sum bits SHALL be carried forward alongside.
REQ-021 Latency SHALL be exactly NBLK cycles from input transfer to out_valid under continuous adv.
REQ-022 Throughput SHALL be one operation per cycle while out_ready = 1; no bubbles are inserted.
REQ-023 In-flight operations SHALL retain order; no operation is dropped or duplicated under any out_ready pattern.
REQ-024 OVF = (carry into MSB) XOR C_OUT for the final stage.
REQ-025 An invalid (bubble) slot SHALL propagate with valid = 0; its data contents are don't-care.
REQ-026 SUM, C_OUT, and OVF SHALL remain stable while out_valid && !out_ready.
REQ-027 in_valid with in_ready = 0 SHALL NOT be captured; the source must hold its operands.

Reset
REQ-028 When reset = 1 at a clock edge, all stage valid bits SHALL clear; out_valid = 0 on the following cycle.
REQ-029 On reset, SUM = 0, C_OUT = 0, and OVF = 0; internal data registers clear to 0.
REQ-030 Reset SHALL override adv and in_valid; operations in flight when reset is asserted are discarded.
REQ-031 in_ready SHALL be 1 during and after reset (out_valid = 0 implies adv = 1).

Structure
REQ-032 Shared package csel_pkg SHALL hold the default WIDTH and BLK constants and the NBLK derivation.
REQ-033 Sub-module csel_block SHALL be instantiated NBLK times: a purely combinational BLK-bit carry-select slice with inputs a, b, cin and outputs s, cout, c_msb_in.
REQ-034 All sequencing, skew registers, and handshake logic SHALL reside in pipelined_csel_adder only.

Verification (WIDTH=16, BLK=4, latency 4)
REQ-035 A=0x00FF, B=0x0001, C_IN=0, SUB=0, out_ready=1 -> 4 cycles later: SUM=0x0100, C_OUT=0, OVF=0.
REQ-036 A=0xFFFF, B=0x0000, C_IN=1 -> SUM=0x0000, C_OUT=1, OVF=0; and A=0x7FFF, B=0x0001 -> SUM=0x8000, OVF=1.
REQ-037 SUB=1 with A=0x0005, B=0x0007 -> SUM=0xFFFE, C_OUT=0; and A=0x8000, B=0x0001 -> SUM=0x7FFF, OVF=1.
REQ-038 Send 8 back-to-back ops with out_ready held 0 from cycle 6 to cycle 10 -> in_ready=0 while stalled, outputs frozen, all 8 results delivered in order, none lost.
REQ-039 Assert reset for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, none of the 3 emerge, and an op issued after reset emerges exactly 4 cycles later.
REQ-040 Random test of 10k ops with random in_valid/out_ready, checked against a reference A±B model -> zero mismatches, including for BLK=1, 2, and 8.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared sizing for the pipelined carry-select adder: default widths and the stage-count derivation.
package csel_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLK   = 4;

  function automatic int nblk(input int width, input int blk);
    return width / blk;
  endfunction

endpackage

// File: rtl/pipelined_csel_adder_if.sv
// Operand/result bus of the pipelined adder; slave is the adder side, master the producer/consumer side.
interface pipelined_csel_adder_if import csel_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_IN;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             C_OUT;
  logic             OVF;

  modport slave (
    input  in_valid, A, B, C_IN, SUB, out_ready,
    output in_ready, out_valid, SUM, C_OUT, OVF
  );

  modport master (
    output in_valid, A, B, C_IN, SUB, out_ready,
    input  in_ready, out_valid, SUM, C_OUT, OVF
  );

endinterface

// File: rtl/csel_block.sv
// Combinational BLK-bit carry-select slice: two ripple sums (carry-in 0 and 1) muxed by the real carry-in.
module csel_block import csel_pkg::*; #(
  parameter int BLK = DEF_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [BLK-1:0] s0, s1;
  logic           c0, c1, m0, m1;

  always_comb begin
    s0 = '0;
    s1 = '0;
    c0 = 1'b0;
    c1 = 1'b1;
    m0 = 1'b0;
    m1 = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      // carry arriving at the slice MSB feeds the overflow detector of the last stage
      if (i == BLK - 1) begin
        m0 = c0;
        m1 = c1;
      end
      s0[i] = a[i] ^ b[i] ^ c0;
      c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      s1[i] = a[i] ^ b[i] ^ c1;
      c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
  end

  assign s        = cin ? s1 : s0;
  assign cout     = cin ? c1 : c0;
  assign c_msb_in = cin ? m1 : m0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor, one BLK-bit block per stage; latency WIDTH/BLK cycles.
// Single global advance: the whole pipe freezes while a result is waiting and out_ready is low.
module pipelined_csel_adder import csel_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input logic                   clk,
  input logic                   reset,
  pipelined_csel_adder_if.slave bus
);

  localparam int NBLK = nblk(WIDTH, BLK);

  logic adv;

  assign adv          = !stg[NBLK-1].v_q || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NBLK; k++) begin : stg
    logic [WIDTH-1:0] a_in, b_in, s_in, s_nxt;
    logic             c_in, v_in;
    logic [BLK-1:0]   blk_s;
    logic             blk_c, blk_m;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_q, m_q, v_q;

    if (k == 0) begin : g_src
      // subtraction is A + ~B + 1; the inversion and forced carry are applied once, up front
      assign a_in = bus.A;
      assign b_in = bus.SUB ? ~bus.B : bus.B;
      assign c_in = bus.SUB | bus.C_IN;
      assign s_in = '0;
      assign v_in = bus.in_valid;
    end else begin : g_skew
      assign a_in = stg[k-1].a_q;
      assign b_in = stg[k-1].b_q;
      assign c_in = stg[k-1].c_q;
      assign s_in = stg[k-1].s_q;
      assign v_in = stg[k-1].v_q;
    end

    csel_block #(.BLK(BLK)) u_blk (
      .a        (a_in[BLK-1:0]),
      .b        (b_in[BLK-1:0]),
      .cin      (c_in),
      .s        (blk_s),
      .cout     (blk_c),
      .c_msb_in (blk_m)
    );

    // unprocessed operand bits shift down so every stage consumes bits [BLK-1:0]
    assign s_nxt = s_in | (WIDTH'(blk_s) << (k * BLK));

    always_ff @(posedge clk) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        m_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        a_q <= a_in >> BLK;
        b_q <= b_in >> BLK;
        s_q <= s_nxt;
        c_q <= blk_c;
        m_q <= blk_m;
        v_q <= v_in;
      end
    end

    if (k == NBLK - 1) begin : g_last
      logic unused_skew;
      assign unused_skew = ^{a_q, b_q};
    end else begin : g_mid
      logic unused_msb;
      assign unused_msb = m_q;
    end
  end

  assign bus.out_valid = stg[NBLK-1].v_q;
  assign bus.SUM       = stg[NBLK-1].s_q;
  assign bus.C_OUT     = stg[NBLK-1].c_q;
  assign bus.OVF       = stg[NBLK-1].m_q ^ stg[NBLK-1].c_q;

endmodule
